fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Issues one instruction-memory read at a time
// from the current PC, captures the returned word into a one-entry output
// buffer together with its address and address+4, and pulses PCWrite so the
// PC register advances. A flush (taken branch / jump) discards both the
// buffered instruction and any read still in flight.
//
// Optional build feature (macro FETCH_TIMEOUT_EN):
//   defined   -> 8-bit stall counter; FetchError becomes a sticky timeout flag
//   undefined -> no counter, FetchError tied low
//
// Ports
//   Clk          in   1   rising-edge clock for all state
//   Rst          in   1   synchronous active-high reset, wins over all inputs
//   PCAddress    in  32   current PC from the program counter register
//   PCWrite      out  1   one-cycle pulse, registered: PC loads its next value
//   MemReq       out  1   one-cycle read request (only ever raised in IDLE)
//   MemAddr      out 32   read address, valid while MemReq=1 (0 otherwise)
//   MemRdValid   in   1   one-cycle pulse, MemRdData valid
//   MemRdData    in  32   instruction word returned by memory
//   Flush        in   1   discard in-flight and buffered instructions
//   InstrReady   in   1   decode accepts Instruction this cycle
//   InstrValid   out  1   output buffer holds a valid instruction
//   Instruction  out 32   buffered instruction word
//   InstrPC      out 32   address the buffered word was fetched from
//   PCPlus4      out 32   InstrPC + 4 (wraps modulo 2^32)
//   FetchError   out  1   sticky fetch-timeout flag
//   DbgState     out  2   current FSM state (0 IDLE, 1 WAIT, 2 DRAIN)
//
// Handshakes
//   Memory side: MemReq is a single-cycle strobe; the next MemRdValid pulse
//   seen in WAIT or DRAIN is the answer to it. Only one read is ever in
//   flight, so no tag is needed. MemRdValid outside WAIT/DRAIN is stale
//   (e.g. the answer to a read abandoned by reset) and is ignored.
//   Decode side: valid/ready. The word transfers on every rising edge where
//   InstrValid=1 and InstrReady=1. Contents are held stable while
//   InstrValid=1 and InstrReady=0. A load on the same edge as a transfer
//   refills the buffer; Flush clears InstrValid regardless of load/transfer.
// -----------------------------------------------------------------------------
module fetch_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PCAddress,
  output logic        PCWrite,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemRdValid,
  input  logic [31:0] MemRdData,
  input  logic        Flush,
  input  logic        InstrReady,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus4,
  output logic        FetchError,
  output logic [1:0]  DbgState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;

  // Address of the read in flight, latched when the request is issued.
  logic [31:0] addr_q, addr_d;

  // One-entry output buffer.
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] pc4_q, pc4_d;

  // PCWrite is registered so it is seen the cycle after the word lands,
  // which keeps it out of WAIT/DRAIN and aligned with InstrValid rising.
  logic        pcw_q, pcw_d;

  logic        issue;
  logic        load;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    pc4_d   = pc4_q;
    pcw_d   = 1'b0;

    // A request may go out when the buffer is empty or being emptied this
    // edge; gating with Rst keeps the strobe low during reset cycles.
    issue = !Rst && (state_q == S_IDLE) && !Flush && (!valid_q || InstrReady);

    // A response is only kept if it arrives in WAIT without a flush.
    load  = (state_q == S_WAIT) && MemRdValid && !Flush;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          addr_d  = PCAddress;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response always ends the wait; a flush without one must still
        // absorb the outstanding response, hence DRAIN.
        if (MemRdValid) begin
          state_d = S_IDLE;
        end else if (Flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Flush is irrelevant here: the response is discarded either way.
        if (MemRdValid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Buffer update; flush dominates load, load dominates consume.
    if (Flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = MemRdData;
      ipc_d   = addr_q;
      pc4_d   = addr_q + 32'd4;
    end else if (valid_q && InstrReady) begin
      valid_d = 1'b0;
    end

    pcw_d = load;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      pc4_q   <= '0;
      pcw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      pc4_q   <= pc4_d;
      pcw_q   <= pcw_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch timeout
  // ---------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       ferr_q, ferr_d;
  logic       tmo_enter;
  logic       tmo_stall;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    ferr_d    = ferr_q;

    // Entering WAIT from IDLE or DRAIN from WAIT restarts the count.
    tmo_enter = ((state_q == S_IDLE) && (state_d == S_WAIT)) ||
                ((state_q == S_WAIT) && (state_d == S_DRAIN));
    tmo_stall = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && !MemRdValid;

    if (tmo_enter) begin
      tmo_cnt_d = 8'd0;
    end else if (tmo_stall && (tmo_cnt_q != 8'hFF)) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end

    if (tmo_cnt_d == 8'hFF) begin
      ferr_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmo_cnt_q <= 8'd0;
      ferr_q    <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      ferr_q    <= ferr_d;
    end
  end

  assign FetchError = ferr_q;
`else
  assign FetchError = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign MemReq      = issue;
  assign MemAddr     = issue ? PCAddress : 32'd0;
  assign PCWrite     = pcw_q;
  assign InstrValid  = valid_q;
  assign Instruction = instr_q;
  assign InstrPC     = ipc_q;
  assign PCPlus4     = pc4_q;
  assign DbgState    = state_q;

endmodule
